// File: rtl/fb_vga_pkg.sv
// Shared timing defaults, frame-buffer geometry and pixel type for the VGA scan-out block.
package fb_vga_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;

  localparam int unsigned H_TOTAL = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int unsigned V_TOTAL = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int unsigned FB_W = 256;
  localparam int unsigned FB_H = 256;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [2:0] b;
  } pixel_t;

  localparam pixel_t PIX_BLANK = '0;

endpackage

// File: rtl/fb_ram.sv
// 65536x9 simple dual-port frame RAM; synchronous read returns old data on a same-address write.
module fb_ram
  import fb_vga_pkg::*;
(
  input  logic        clk_i,
  input  logic        we_i,
  input  logic [15:0] waddr_i,
  input  pixel_t      wdata_i,
  input  logic        re_i,
  input  logic [15:0] raddr_i,
  output pixel_t      rdata_o
);

  pixel_t mem [0:65535];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (re_i) rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/fb_vga_out.sv
// Captures the drawing engine's pixel stream into a 256x256 frame RAM and scans it out
// as VGA with the image centred on a border colour; two-tick output pipeline.
module fb_vga_out
  import fb_vga_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 2,
  parameter int unsigned H_ACTIVE   = H_ACTIVE_DEF,
  parameter int unsigned H_FP       = H_FP_DEF,
  parameter int unsigned H_SYNC     = H_SYNC_DEF,
  parameter int unsigned H_BP       = H_BP_DEF,
  parameter int unsigned V_ACTIVE   = V_ACTIVE_DEF,
  parameter int unsigned V_FP       = V_FP_DEF,
  parameter int unsigned V_SYNC     = V_SYNC_DEF,
  parameter int unsigned V_BP       = V_BP_DEF,
  parameter int unsigned X_OFS      = 192,
  parameter int unsigned Y_OFS      = 112,
  parameter logic [8:0]  BORDER_RGB = 9'h000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       WE,
  input  logic [7:0] WX,
  input  logic [7:0] WY,
  input  logic [2:0] WR,
  input  logic [2:0] WG,
  input  logic [2:0] WB,
  output logic       VGA_HS,
  output logic       VGA_VS,
  output logic [2:0] VGA_R,
  output logic [2:0] VGA_G,
  output logic [2:0] VGA_B,
  output logic       VGA_DE,
  output logic       FRAME_START
);

  localparam int unsigned H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0] div_q, div_d;
  logic             tick;
  logic [9:0]       hcnt_q, hcnt_d, vcnt_q, vcnt_d;

  logic [9:0]  xrel, yrel;
  logic        hs0, vs0, de0, win0, first0;
  logic [15:0] raddr;

  logic   hs1_q, vs1_q, de1_q, win1_q, first1_q;
  pixel_t rdata;

  logic   hs2_q, vs2_q, de2_q, fs2_q, fs2_d;
  pixel_t rgb2_q, rgb2_d;

  always_comb begin
    tick   = (div_q == DIV_W'(CLK_DIV - 1));
    div_d  = tick ? '0 : div_q + DIV_W'(1);
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (tick) begin
      if (hcnt_q == 10'(H_TOT - 1)) begin
        hcnt_d = '0;
        vcnt_d = (vcnt_q == 10'(V_TOT - 1)) ? '0 : vcnt_q + 10'd1;
      end else begin
        hcnt_d = hcnt_q + 10'd1;
      end
    end
  end

  // Offsets wrap modulo 1024, so positions left of/above the window fail the < 256 test.
  always_comb begin
    xrel   = hcnt_q - 10'(X_OFS);
    yrel   = vcnt_q - 10'(Y_OFS);
    hs0    = !(hcnt_q >= 10'(H_ACTIVE + H_FP) && hcnt_q < 10'(H_ACTIVE + H_FP + H_SYNC));
    vs0    = !(vcnt_q >= 10'(V_ACTIVE + V_FP) && vcnt_q < 10'(V_ACTIVE + V_FP + V_SYNC));
    de0    = (hcnt_q < 10'(H_ACTIVE)) && (vcnt_q < 10'(V_ACTIVE));
    win0   = de0 && (xrel < 10'(FB_W)) && (yrel < 10'(FB_H));
    first0 = (hcnt_q == '0) && (vcnt_q == '0);
    raddr  = {yrel[7:0], xrel[7:0]};
  end

  fb_ram u_ram (
    .clk_i   (CLK),
    .we_i    (WE),
    .waddr_i ({WY, WX}),
    .wdata_i (pixel_t'({WR, WG, WB})),
    .re_i    (tick),
    .raddr_i (raddr),
    .rdata_o (rdata)
  );

  always_comb begin
    rgb2_d = win1_q ? rdata : (de1_q ? pixel_t'(BORDER_RGB) : PIX_BLANK);
    fs2_d  = tick && first1_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      div_q    <= '0;
      hcnt_q   <= '0;
      vcnt_q   <= '0;
      hs1_q    <= 1'b1;
      vs1_q    <= 1'b1;
      de1_q    <= 1'b0;
      win1_q   <= 1'b0;
      first1_q <= 1'b0;
      hs2_q    <= 1'b1;
      vs2_q    <= 1'b1;
      de2_q    <= 1'b0;
      rgb2_q   <= PIX_BLANK;
      fs2_q    <= 1'b0;
    end else begin
      div_q  <= div_d;
      hcnt_q <= hcnt_d;
      vcnt_q <= vcnt_d;
      fs2_q  <= fs2_d;
      if (tick) begin
        hs1_q    <= hs0;
        vs1_q    <= vs0;
        de1_q    <= de0;
        win1_q   <= win0;
        first1_q <= first0;
        hs2_q    <= hs1_q;
        vs2_q    <= vs1_q;
        de2_q    <= de1_q;
        rgb2_q   <= rgb2_d;
      end
    end
  end

  assign VGA_HS      = hs2_q;
  assign VGA_VS      = vs2_q;
  assign VGA_DE      = de2_q;
  assign VGA_R       = rgb2_q.r;
  assign VGA_G       = rgb2_q.g;
  assign VGA_B       = rgb2_q.b;
  assign FRAME_START = fs2_q;

endmodule

// File: tb/tb_fb_vga_out.sv
// Scoreboard bench for fb_vga_out on a shrunken raster; a frame-level model predicts every CLK's pins.
module tb_fb_vga_out;

  localparam int CD  = 2;
  localparam int HA  = 264, HF = 4, HS = 8, HB = 4;
  localparam int VA  = 8,   VF = 1, VS = 2, VB = 1;
  localparam int HT  = HA + HF + HS + HB;
  localparam int VT  = VA + VF + VS + VB;
  localparam int XO  = 4, YO = 2;
  localparam logic [8:0] BRD = 9'h1C0;
  localparam int FT   = HT * VT;
  localparam int FCLK = FT * CD;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       de;
    logic       fs;
    logic [8:0] rgb;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       we  = 1'b0;
  logic [7:0] wx  = '0;
  logic [7:0] wy  = '0;
  logic [8:0] wrgb = '0;

  logic       vga_hs, vga_vs, vga_de, frame_start;
  logic [2:0] vga_r, vga_g, vga_b;

  fb_vga_out #(
    .CLK_DIV(CD), .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .X_OFS(XO), .Y_OFS(YO), .BORDER_RGB(BRD)
  ) dut (
    .CLK(clk), .RST(rst), .WE(we), .WX(wx), .WY(wy),
    .WR(wrgb[8:6]), .WG(wrgb[5:3]), .WB(wrgb[2:0]),
    .VGA_HS(vga_hs), .VGA_VS(vga_vs),
    .VGA_R(vga_r), .VGA_G(vga_g), .VGA_B(vga_b),
    .VGA_DE(vga_de), .FRAME_START(frame_start)
  );

  always #5 clk = ~clk;

  // Reference: screen position p (ticks since reset) -> what the pins show for it.
  logic [8:0] mm [0:65535];
  exp_t       expq[$];
  exp_t       last_e;
  int         c_since_rst;
  logic [8:0] rd_prev;
  int         vectors = 0;
  int         miscompares = 0;

  function automatic exp_t pix(input int p, input logic [8:0] rd);
    exp_t e;
    int h, v;
    logic win;
    h = p % HT;
    v = (p / HT) % VT;
    e.hs  = !(h >= HA + HF && h < HA + HF + HS);
    e.vs  = !(v >= VA + VF && v < VA + VF + VS);
    e.de  = (h < HA) && (v < VA);
    win   = e.de && h >= XO && h < XO + 256 && v >= YO && v < YO + 256;
    e.rgb = win ? rd : (e.de ? BRD : 9'h000);
    e.fs  = (p % FT) == 0;
    return e;
  endfunction

  function automatic int addr_of(input int p);
    int h, v;
    h = p % HT;
    v = (p / HT) % VT;
    return ((v - YO) & 255) * 256 + ((h - XO) & 255);
  endfunction

  always @(posedge clk) begin
    exp_t e;
    int n;
    if (rst) begin
      e = '{hs: 1'b1, vs: 1'b1, de: 1'b0, fs: 1'b0, rgb: 9'h000};
      c_since_rst = 0;
    end else begin
      e = last_e;
      e.fs = 1'b0;
      if (c_since_rst % CD == CD - 1) begin
        n = c_since_rst / CD;
        if (n == 0) e = '{hs: 1'b1, vs: 1'b1, de: 1'b0, fs: 1'b0, rgb: 9'h000};
        else        e = pix(n - 1, rd_prev);
        rd_prev = mm[addr_of(n)];
      end
      c_since_rst++;
    end
    if (we) mm[{wy, wx}] = wrgb;
    last_e = e;
    expq.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e, got;
    if (expq.size() != 0) begin
      e   = expq.pop_front();
      got = '{hs: vga_hs, vs: vga_vs, de: vga_de, fs: frame_start, rgb: {vga_r, vga_g, vga_b}};
      vectors++;
      if (got !== e) begin
        miscompares++;
        $display("FAIL pins@%0t: got hs=%b vs=%b de=%b fs=%b rgb=%h, want hs=%b vs=%b de=%b fs=%b rgb=%h",
                 $time, got.hs, got.vs, got.de, got.fs, got.rgb, e.hs, e.vs, e.de, e.fs, e.rgb);
      end
    end
  end

  initial begin
    bit seen;
    seen = 1'b0;
    @(negedge rst);
    fork
      begin
        @(posedge frame_start);
        seen = 1'b1;
      end
      repeat (FCLK + 16) @(posedge clk);
    join_any
    disable fork;
    if (!seen) begin
      miscompares++;
      $display("FAIL timeout@%0t: no FRAME_START within %0d CLK after reset release", $time, FCLK + 16);
    end
  end

  initial begin
    int target, rst_k, total;
    // Frame 1, scan of (x=10, y=1): write lands on the very edge that reads it.
    target = (FT + (YO + 1) * HT + XO + 10) * CD + CD - 1;
    rst_k  = 3 * FCLK + 5 * HT * CD + 37;
    total  = 5 * FCLK + 200;

    for (int y = 0; y < 6; y++) begin
      for (int x = 0; x < 256; x++) begin
        @(negedge clk);
        rst = 1'b1; we = 1'b1; wx = 8'(x); wy = 8'(y); wrgb = 9'($urandom);
      end
    end
    @(negedge clk); wx = 8'd0;   wy = 8'd0; wrgb = 9'h03F;
    if ({vga_hs, vga_vs, vga_de, frame_start, vga_r, vga_g, vga_b} !== {1'b1, 1'b1, 1'b0, 1'b0, 9'h000}) begin
      miscompares++;
      $display("FAIL reset@%0t: hs=%b vs=%b de=%b fs=%b rgb=%h, want 1 1 0 0 000",
               $time, vga_hs, vga_vs, vga_de, frame_start, {vga_r, vga_g, vga_b});
    end
    @(negedge clk); wx = 8'd255; wy = 8'd0; wrgb = 9'h1C0;
    @(negedge clk); wx = 8'd10;  wy = 8'd1; wrgb = 9'h1FF;

    for (int k = 0; k < total; k++) begin
      @(negedge clk);
      rst = (k == rst_k);
      if (k == target) begin
        we = 1'b1; wx = 8'd10; wy = 8'd1; wrgb = 9'h053;
      end else if (k >= 2 * FCLK) begin
        we = 1'($urandom); wx = 8'($urandom); wy = 8'($urandom_range(0, 7)); wrgb = 9'($urandom);
      end else begin
        we = 1'b0;
      end
    end
    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    if (miscompares == 0) $display("PASS");
    else                  $display("FAIL");
    $finish;
  end

endmodule

// File: doc/fb_vga_out.md
Name: fb_vga_out

Overview:
- Downstream stage of the pixel drawing engine.
- Captures its per-cycle pixel stream (8-bit X/Y, 3-bit R/G/B) into a 256x256x9 frame RAM.
- Scans the RAM out as a standard 640x480@60 VGA signal, with the 256x256 image centred on a solid border colour.
- Everything runs on the single system clock; a clock-enable divider produces the pixel tick.

Parameters:
- CLK_DIV, 2: system clocks per pixel tick (50 MHz CLK -> 25 MHz pixel rate); must be >= 1.
- H_ACTIVE, 640: visible pixels per line.
- H_FP, 16: horizontal front porch, in ticks.
- H_SYNC, 96: horizontal sync width, in ticks.
- H_BP, 48: horizontal back porch, in ticks.
- V_ACTIVE, 480: visible lines per frame.
- V_FP, 10: vertical front porch, in lines.
- V_SYNC, 2: vertical sync width, in lines.
- V_BP, 33: vertical back porch, in lines.
- X_OFS, 192: first hcnt of the image window.
- Y_OFS, 112: first vcnt of the image window.
- BORDER_RGB, 9'h000: {R,G,B} shown inside the active area but outside the window.

Ports:
- CLK  in  1  system clock
- RST  in  1  synchronous, active-high reset
- WE  in  1  write enable; tie to 1 for a free-running drawing engine
- WX  in  8  write column
- WY  in  8  write row
- WR  in  3  write red
- WG  in  3  write green
- WB  in  3  write blue
- VGA_HS  out  1  horizontal sync, active low
- VGA_VS  out  1  vertical sync, active low
- VGA_R  out  3  pixel red
- VGA_G  out  3  pixel green
- VGA_B  out  3  pixel blue
- VGA_DE  out  1  data-enable, high in the visible area
- FRAME_START  out  1  one-CLK pulse at the start of each frame

Behaviour:
- Reset and clocking (already decided): one clock, CLK. RST is synchronous and active-high and takes effect on the CLK edge.
- Reset values:
  - tick divider, hcnt and vcnt = 0.
  - VGA_HS = VGA_VS = 1.
  - VGA_R/G/B = 0, VGA_DE = 0, FRAME_START = 0.
  - Pipeline registers cleared to their idle (blank) values.
  - RAM contents are NOT cleared.
- Write port:
  - Every CLK edge with WE=1: mem[{WY,WX}] <= {WR,WG,WB}.
  - Writes are independent of the pixel tick and honoured during RST.
  - No back-pressure; the writer never stalls.
- Tick divider:
  - Counts 0..CLK_DIV-1; tick = (div == CLK_DIV-1).
  - With CLK_DIV=1, tick is constantly 1.
  - All scan logic advances only on tick.
- Counters:
  - hcnt runs 0..H_TOTAL-1, where H_TOTAL = sum of the H parameters (800).
  - On hcnt wrap, vcnt increments over 0..V_TOTAL-1 (525).
  - Both counters wrap to 0 together at the frame end.
- Stage 0 (combinational, from the counters):
  - hs0 = !(hcnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC)).
  - vs0 likewise, using the V parameters.
  - de0 = hcnt<H_ACTIVE && vcnt<V_ACTIVE.
  - win0 = de0 && hcnt-X_OFS<256 && vcnt-Y_OFS<256 (unsigned compares).
  - raddr = {vcnt-Y_OFS, hcnt-X_OFS}, each term truncated to 8 bits.
- Stage 1 (on tick):
  - RAM read registered; hs/vs/de/win delayed one stage.
- Stage 2 (on tick):
  - Output registers load:
    - rgb = win1 ? rdata : (de1 ? BORDER_RGB : 0).
    - VGA_HS/VS/DE from stage 1.
  - Latency: pins at tick t reflect the counters at tick t-2. All outputs stay mutually aligned.
- FRAME_START:
  - High for exactly one CLK when the stage-2 registers load values from hcnt=0, vcnt=0.
- Read-during-write:
  - Same address on the same CLK edge: the read returns the old data.
  - A write becomes visible on the next frame scan of that address.
- Reset mid-frame:
  - On the next edge, outputs return to reset values and the scan restarts at hcnt=vcnt=0.
  - Blank pixels are output for the two pipeline ticks.
- Widths: hcnt is 10 bits and vcnt is 10 bits; sync comparisons use full widths.

Decomposition:
- Shared package fb_vga_pkg holds:
  - the timing constants (H_/V_ defaults, H_TOTAL, V_TOTAL);
  - the 9-bit pixel type {R,G,B};
  - FB_W = FB_H = 256.
- One sub-module, fb_ram: simple dual-port 65536x9, synchronous write, synchronous read with a read-enable (driven by tick) and old-data read-during-write. It infers block RAM.

Test Plan:
- Reset then run with CLK_DIV=2 -> VGA_HS low for 96 ticks every 800 ticks; VGA_VS low for 2 lines every 525 lines; VGA_DE high for 640x480; FRAME_START once per 840000 CLK.
- Write {0,7,7} to (X=0,Y=0) and {7,0,0} to (255,255); scan -> pixel at hcnt=192,vcnt=112 is G=7,B=7; hcnt=447,vcnt=367 is R=7; hcnt=191 and hcnt=448 show BORDER_RGB.
- Set BORDER_RGB=9'h1C0 -> visible pixels outside the window read R=7,G=0,B=0; blanking interval pixels read 0.
- Write (10,20) with {1,2,3} on the same CLK edge as it is read -> old value appears this frame; {1,2,3} appears next frame.
- Assert RST for 1 CLK at vcnt=300 -> next CLK: HS=VS=1, RGB=0, DE=0; first FRAME_START follows 2 ticks after reset release.
- CLK_DIV=1, WE held at 1 with a full 65536-address sweep of pixel = addr[8:0] -> every window pixel matches its address with zero mismatches.
